// File: rtl/unit_buffer_pkg.sv
// Shared defaults for the clock-buffer cell models: propagation delay,
// minimum legal clock phase and edge-counter width.
`timescale 1ns/100ps
package unit_buffer_pkg;

  // clk-to-out propagation delay, in ns
  localparam real DELAY_DEFAULT = 1.0;

  // shortest legal clk high or low phase, in ns
  localparam real MIN_PULSE_DEFAULT = 2.0;

  // width of the rising-edge counter
  localparam int unsigned CNT_W_DEFAULT = 16;

  // True when an elapsed phase (ns) is shorter than the legal minimum.
  function automatic logic phase_too_short(input real elapsed, input real min_pulse);
    return (elapsed < min_pulse);
  endfunction

endpackage

// File: rtl/unit_buffer_clk_phase_monitor.sv
// clk_phase_monitor: counts clk rising edges and flags any clk phase
// shorter than MIN_PULSE. Edges are time-stamped with $realtime, so this
// is a simulation model, not synthesizable logic.
`timescale 1ns/100ps
module clk_phase_monitor
  import unit_buffer_pkg::*;
#(
  parameter real         MIN_PULSE = MIN_PULSE_DEFAULT,
  parameter int unsigned CNT_W     = CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [CNT_W-1:0] edge_cnt_o,
  output logic             glitch_o
);

  logic [CNT_W-1:0] edge_cnt_q;
  logic [CNT_W-1:0] edge_cnt_d;
  logic             glitch_q;
  logic             stamp_vld_q;
  logic             clk_prev_q;
  real              stamp_q;

  // Next count value; wraps from all-ones to zero silently.
  always_comb begin
    edge_cnt_d = edge_cnt_q + CNT_W'(1);
  end

  // Time-stamp every clk edge, count rising edges and latch short phases.
  // Only a hard 0 on rst_ni resets, so a floating reset reads as released.
  // clk_prev_q filters out activations caused by rst_ni alone.
  always @(posedge clk_i or negedge clk_i or negedge rst_ni) begin
    if (rst_ni === 1'b0) begin
      edge_cnt_q  <= '0;
      glitch_q    <= 1'b0;
      stamp_vld_q <= 1'b0;
      stamp_q     <= 0.0;
      clk_prev_q  <= clk_i;
    end else if (clk_i !== clk_prev_q) begin
      clk_prev_q <= clk_i;
      if ((clk_i === 1'b1) && (clk_prev_q === 1'b0)) begin
        edge_cnt_q <= edge_cnt_d;
      end
      // The first edge after reset has nothing to time against.
      if (stamp_vld_q && phase_too_short($realtime - stamp_q, MIN_PULSE)) begin
        glitch_q <= 1'b1;
      end
      stamp_q     <= $realtime;
      stamp_vld_q <= 1'b1;
    end
  end

  assign edge_cnt_o = edge_cnt_q;
  assign glitch_o   = glitch_q;

endmodule

// File: rtl/unit_buffer.sv
// unit_buffer: clock buffer simulation model. out is clk delayed by DELAY
// with transport semantics; the delay path uses an intra-assignment delay
// and is NOT synthesizable. A phase monitor reports edge count and glitches
// and never touches out.
`timescale 1ns/100ps
module unit_buffer
  import unit_buffer_pkg::*;
#(
  parameter real         DELAY     = DELAY_DEFAULT,
  parameter real         MIN_PULSE = MIN_PULSE_DEFAULT,
  parameter int unsigned CNT_W     = CNT_W_DEFAULT
) (
  input  logic             clk,
  output logic             out,
  input  logic             rst_n,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             glitch
);

  logic out_q;

  // Transport delay: every clk transition is scheduled DELAY later, so
  // pulses narrower than DELAY still reach out. XOR with 0 turns a Z on
  // clk into X on out.
  always @(clk) begin
    out_q <= #(DELAY) (clk ^ 1'b0);
  end

  assign out = out_q;

  clk_phase_monitor #(
    .MIN_PULSE (MIN_PULSE),
    .CNT_W     (CNT_W)
  ) u_monitor (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .edge_cnt_o (edge_cnt),
    .glitch_o   (glitch)
  );

endmodule

// File: tb/tb_unit_buffer.sv
// Directed bench for unit_buffer. Time is handled in 0.1 ns ticks; the
// stimulus acts on whole ticks and the compare process samples half a tick
// later, so no sample lands on a clk edge or on edge+DELAY.
`timescale 1ns/10ps
module tb_unit_buffer;

  logic        clk;
  logic        rst_n;
  logic        out16, out4;
  logic        glitch16, glitch4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  int vectors     = 0;
  int miscompares = 0;

  // Event history, in ticks of 0.1 ns. Entry 0 of each is the initial value.
  int   clk_t[$];
  logic clk_v[$];
  int   rst_t[$];
  logic rst_v[$];

  localparam int LAST_TICK  = 1880;
  localparam int DELAY_TK   = 10;   // 1.0 ns
  localparam int MIN_PUL_TK = 20;   // 2.0 ns

  unit_buffer u_dut (
    .clk      (clk),
    .out      (out16),
    .rst_n    (rst_n),
    .edge_cnt (cnt16),
    .glitch   (glitch16)
  );

  unit_buffer #(.CNT_W(4)) u_dut4 (
    .clk      (clk),
    .out      (out4),
    .rst_n    (rst_n),
    .edge_cnt (cnt4),
    .glitch   (glitch4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0.2f ns: got %0h, expected %0h", name, $realtime, act, exp);
    end
  endtask

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, act, exp);
    $display("vector %-12s t=%0.2f ns act=%0h exp=%0h", name, $realtime, act, exp);
  endtask

  // Value of clk after all events at or before tick s.
  function automatic logic clk_at(input int s);
    logic v = clk_v[0];
    for (int i = 0; i < clk_t.size(); i++) if (clk_t[i] <= s) v = clk_v[i];
    return v;
  endfunction

  function automatic logic rst_at(input int s);
    logic v = rst_v[0];
    for (int i = 0; i < rst_t.size(); i++) if (rst_t[i] <= s) v = rst_v[i];
    return v;
  endfunction

  // Monitor expectation: count rising edges since the last reset release
  // and look for two consecutive edges closer than MIN_PULSE.
  function automatic void mon_model(input int s, output int cnt, output logic gl);
    int last_rise = -1;
    int prev      = -1;
    cnt = 0;
    gl  = 1'b0;
    if (rst_at(s) == 1'b0) return;
    for (int i = 0; i < rst_t.size(); i++)
      if (rst_t[i] <= s && rst_v[i] == 1'b1 && (i == 0 || rst_v[i-1] == 1'b0))
        last_rise = rst_t[i];
    for (int i = 1; i < clk_t.size(); i++) begin
      if (clk_t[i] > last_rise && clk_t[i] <= s) begin
        if (clk_v[i] == 1'b1) cnt++;
        if (prev >= 0 && (clk_t[i] - prev) < MIN_PUL_TK) gl = 1'b1;
        prev = clk_t[i];
      end
    end
  endfunction

  task automatic drive_clk(input logic v, input int k);
    clk = v;
    clk_t.push_back(k);
    clk_v.push_back(v);
  endtask

  task automatic drive_rst(input logic v, input int k);
    rst_n = v;
    rst_t.push_back(k);
    rst_v.push_back(v);
  endtask

  // Stimulus: 8 ns clock, a 1 ns high pulse injected in the low phase at
  // 145 ns, and resets at 0-10, 161.3-163.3 and 172-175 ns (the last one
  // lands on a clk rising edge). Hand-computed pins are checked here.
  initial begin
    drive_clk(1'b0, 0);
    drive_rst(1'b0, 0);
    for (int k = 1; k <= LAST_TICK; k++) begin
      #0.1;
      case (k)
        20:   pin("out@2.0",    32'(out16), 32'd0);
        45:   pin("out@4.5",    32'(out16), 32'd0);
        51:   pin("out@5.1",    32'(out16), 32'd1);
        855: begin
              pin("cnt@85.5",   32'(cnt16), 32'd10);
              pin("glt@85.5",   32'(glitch16), 32'd0);
        end
        1405: begin
              pin("cnt16@140",  32'(cnt16), 32'd17);
              pin("cnt4@140",   32'(cnt4), 32'd1);
        end
        1455: pin("glt@145.5",  32'(glitch16), 32'd1);
        1465: pin("out@146.5",  32'(out16), 32'd1);
        1475: pin("out@147.5",  32'(out16), 32'd0);
        1605: pin("glt@160.5",  32'(glitch16), 32'd1);
        1625: begin
              pin("glt@162.5",  32'(glitch16), 32'd0);
              pin("cnt@162.5",  32'(cnt16), 32'd0);
        end
        1645: begin
              pin("cnt@164.5",  32'(cnt16), 32'd1);
              pin("glt@164.5",  32'(glitch16), 32'd0);
        end
        1725: pin("cnt@172.5",  32'(cnt16), 32'd0);
        1805: pin("cnt@180.5",  32'(cnt16), 32'd1);
        default: ;
      endcase
      if ((k % 40) == 0 || k == 1450 || k == 1460) drive_clk(~clk, k);
      case (k)
        100, 1633, 1750: drive_rst(1'b1, k);
        1613, 1720:      drive_rst(1'b0, k);
        default: ;
      endcase
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Compare process: every half-tick sample checks both instances against
  // the model. out is clk one DELAY earlier regardless of reset activity.
  initial begin
    int   ec;
    logic eg;
    #0.05;
    for (int s = 0; s < LAST_TICK; s++) begin
      mon_model(s, ec, eg);
      if (s >= DELAY_TK) begin
        chk("out16", 32'(out16), 32'(clk_at(s - DELAY_TK)));
        chk("out4",  32'(out4),  32'(clk_at(s - DELAY_TK)));
      end
      chk("edge_cnt16", 32'(cnt16), 32'(ec % 65536));
      chk("edge_cnt4",  32'(cnt4),  32'(ec % 16));
      chk("glitch16",   32'(glitch16), 32'(eg));
      chk("glitch4",    32'(glitch4),  32'(eg));
      #0.1;
    end
  end

endmodule
